// File: rtl/layer_norm_feeder.sv
// Streams one row of int8 activations plus bf16 gamma/beta into the LayerNorm input ports.
// Optional read-back watchdog in WAIT is enabled by defining LN_FEED_TIMEOUT_EN.
module layer_norm_feeder #(
  parameter int BUS_NUM         = 8,
  parameter int DATA_NUM_WIDTH  = 10,
  parameter int SCALA_POS_WIDTH = 5,
  parameter int sig_width       = 7,
  parameter int exp_width       = 8,
  parameter int ADDR_WIDTH      = 8,
  parameter int TIMEOUT_WIDTH   = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DATA_NUM_WIDTH-1:0]         start_data_num,
  input  logic [ADDR_WIDTH-1:0]             start_base_addr,
  input  logic signed [SCALA_POS_WIDTH-1:0] start_in_scale_pos,
  input  logic signed [SCALA_POS_WIDTH-1:0] start_out_scale_pos,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic                              act_rd_en,
  output logic [ADDR_WIDTH-1:0]             act_rd_addr,
  input  logic [BUS_NUM*8-1:0]              act_rd_data,
  output logic                              par_rd_en,
  output logic [ADDR_WIDTH-1:0]             par_rd_addr,
  input  logic [2*BUS_NUM*(sig_width+exp_width+1)-1:0] par_rd_data,
  output logic [DATA_NUM_WIDTH-1:0]         in_data_num,
  output logic                              in_data_num_vld,
  output logic signed [SCALA_POS_WIDTH-1:0] in_scale_pos,
  output logic                              in_scale_pos_vld,
  output logic signed [SCALA_POS_WIDTH-1:0] out_scale_pos,
  output logic                              out_scale_pos_vld,
  output logic [BUS_NUM*8-1:0]              in_fixed_data,
  output logic [BUS_NUM-1:0]                in_fixed_data_vld,
  output logic [BUS_NUM*(sig_width+exp_width+1)-1:0] in_gamma,
  output logic [BUS_NUM-1:0]                in_gamma_vld,
  output logic [BUS_NUM*(sig_width+exp_width+1)-1:0] in_beta,
  output logic [BUS_NUM-1:0]                in_beta_vld,
  input  logic                              ln_last
);
  localparam int FW = sig_width + exp_width + 1;
  localparam int CW = DATA_NUM_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, CFG, STREAM, DRAIN, WAIT} state_t;
  state_t state, state_nxt;

  logic [DATA_NUM_WIDTH-1:0]         num_q;
  logic [ADDR_WIDTH-1:0]             base_q;
  logic signed [SCALA_POS_WIDTH-1:0] in_pos_q, out_pos_q;
  logic [CW-1:0]                     last_k_q, k_q;
  logic [BUS_NUM-1:0]                last_mask_q, rd_mask;
  logic                              drain_q, rd_en, done_nxt, err_nxt, accept;
  logic [CW-1:0]                     n_ext, words_c, last_k_c, rem_c;
  logic [BUS_NUM-1:0]                vld_p0, vld_p1;
  logic [BUS_NUM*8-1:0]              act_p1;
  logic [2*BUS_NUM*FW-1:0]           par_p1;

  function automatic logic [BUS_NUM-1:0] lane_mask(input logic [CW-1:0] rem);
    for (int i = 0; i < BUS_NUM; i++) lane_mask[i] = (CW'(i) < rem);
  endfunction

  // Word count and partial-word lane count derived from the command
  always_comb begin
    n_ext    = CW'(start_data_num);
    words_c  = (n_ext + CW'(BUS_NUM - 1)) / CW'(BUS_NUM);
    last_k_c = words_c - CW'(1);
    rem_c    = n_ext - last_k_c * CW'(BUS_NUM);
  end

  assign accept  = (state == IDLE) && start;
  assign rd_mask = (k_q == last_k_q) ? last_mask_q : '1;

`ifdef LN_FEED_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};
  logic [TIMEOUT_WIDTH-1:0] tmo_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (start_data_num != '0) state_nxt = CFG;
          else                      done_nxt  = 1'b1;
        end
      end
      CFG: begin
        rd_en     = 1'b1;
        state_nxt = (last_k_q == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        rd_en = 1'b1;
        if (k_q == last_k_q) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_q) state_nxt = WAIT;
      end
      WAIT: begin
        if (ln_last) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
`ifdef LN_FEED_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers and lane-valid pipeline: p0 aligns with read data, p1 with outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      done    <= 1'b0;
      k_q     <= '0;
      drain_q <= 1'b0;
      vld_p0  <= '0;
      vld_p1  <= '0;
    end else begin
      done    <= done_nxt;
      k_q     <= rd_en ? k_q + CW'(1) : '0;
      drain_q <= (state == DRAIN) && !drain_q;
      vld_p0  <= rd_en ? rd_mask : '0;
      vld_p1  <= vld_p0;
    end
  end

`ifdef LN_FEED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err   <= 1'b0;
      tmo_q <= '0;
    end else begin
      err   <= err_nxt;
      tmo_q <= (state == WAIT) ? tmo_q + 1'b1 : '0;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Command latch and data capture; outputs are gated by vld_p1 so these need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      num_q       <= start_data_num;
      base_q      <= start_base_addr;
      in_pos_q    <= start_in_scale_pos;
      out_pos_q   <= start_out_scale_pos;
      last_k_q    <= last_k_c;
      last_mask_q <= lane_mask(rem_c);
    end
    act_p1 <= act_rd_data;
    par_p1 <= par_rd_data;
  end

  assign busy        = (state != IDLE);
  assign act_rd_en   = rd_en;
  assign par_rd_en   = rd_en;
  assign act_rd_addr = rd_en ? base_q + ADDR_WIDTH'(k_q) : '0;
  assign par_rd_addr = rd_en ? ADDR_WIDTH'(k_q) : '0;

  assign in_data_num       = (state == CFG) ? num_q : '0;
  assign in_scale_pos      = (state == CFG) ? in_pos_q : '0;
  assign out_scale_pos     = (state == CFG) ? out_pos_q : '0;
  assign in_data_num_vld   = (state == CFG);
  assign in_scale_pos_vld  = (state == CFG);
  assign out_scale_pos_vld = (state == CFG);

  assign in_fixed_data_vld = vld_p1;
  assign in_gamma_vld      = vld_p1;
  assign in_beta_vld       = vld_p1;

  for (genvar i = 0; i < BUS_NUM; i++) begin : g_lane
    assign in_fixed_data[i*8 +: 8] = vld_p1[i] ? act_p1[i*8 +: 8] : '0;
    assign in_gamma[i*FW +: FW]    = vld_p1[i] ? par_p1[i*FW +: FW] : '0;
    assign in_beta[i*FW +: FW]     = vld_p1[i] ? par_p1[BUS_NUM*FW + i*FW +: FW] : '0;
  end

endmodule

// File: tb/tb_layer_norm_feeder.sv
// Directed bench for layer_norm_feeder: buffer model plus read/beat scoreboard with cycle stamps.
module tb_layer_norm_feeder;
  localparam int BUS_NUM = 8;
  localparam int DNW     = 10;
  localparam int SPW     = 5;
  localparam int FW      = 16;
  localparam int AW      = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [DNW-1:0]        start_data_num = '0;
  logic [AW-1:0]         start_base_addr = '0;
  logic signed [SPW-1:0] start_in_scale_pos = '0;
  logic signed [SPW-1:0] start_out_scale_pos = '0;
  logic                  busy, done, err;
  logic                  act_rd_en, par_rd_en;
  logic [AW-1:0]         act_rd_addr, par_rd_addr;
  logic [BUS_NUM*8-1:0]  act_rd_data = '0;
  logic [2*BUS_NUM*FW-1:0] par_rd_data = '0;
  logic [DNW-1:0]        in_data_num;
  logic                  in_data_num_vld, in_scale_pos_vld, out_scale_pos_vld;
  logic signed [SPW-1:0] in_scale_pos, out_scale_pos;
  logic [BUS_NUM*8-1:0]  in_fixed_data;
  logic [BUS_NUM-1:0]    in_fixed_data_vld, in_gamma_vld, in_beta_vld;
  logic [BUS_NUM*FW-1:0] in_gamma, in_beta;
  logic                  ln_last = 1'b0;

  always #5 clk = ~clk;

  layer_norm_feeder dut (
    .clk(clk), .rst(rst), .start(start), .start_data_num(start_data_num),
    .start_base_addr(start_base_addr), .start_in_scale_pos(start_in_scale_pos),
    .start_out_scale_pos(start_out_scale_pos), .busy(busy), .done(done), .err(err),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
    .par_rd_en(par_rd_en), .par_rd_addr(par_rd_addr), .par_rd_data(par_rd_data),
    .in_data_num(in_data_num), .in_data_num_vld(in_data_num_vld),
    .in_scale_pos(in_scale_pos), .out_scale_pos(out_scale_pos),
    .in_scale_pos_vld(in_scale_pos_vld), .out_scale_pos_vld(out_scale_pos_vld),
    .in_fixed_data(in_fixed_data), .in_fixed_data_vld(in_fixed_data_vld),
    .in_gamma(in_gamma), .in_beta(in_beta), .in_gamma_vld(in_gamma_vld),
    .in_beta_vld(in_beta_vld), .ln_last(ln_last)
  );

  function automatic logic [BUS_NUM*8-1:0] act_word(input logic [AW-1:0] a);
    for (int i = 0; i < BUS_NUM; i++) act_word[i*8 +: 8] = a + 8'(i * 37);
  endfunction
  function automatic logic [BUS_NUM*FW-1:0] gamma_word(input logic [AW-1:0] a);
    for (int i = 0; i < BUS_NUM; i++) gamma_word[i*FW +: FW] = {a, 8'(i + 1)};
  endfunction
  function automatic logic [BUS_NUM*FW-1:0] beta_word(input logic [AW-1:0] a);
    for (int i = 0; i < BUS_NUM; i++) beta_word[i*FW +: FW] = {8'(i) ^ 8'hC3, a};
  endfunction

  // Buffer model: one-cycle read latency, garbage when not enabled
  always @(posedge clk) begin
    act_rd_data <= act_rd_en ? act_word(act_rd_addr) : {$urandom, $urandom};
    par_rd_data <= par_rd_en ? {beta_word(par_rd_addr), gamma_word(par_rd_addr)}
                             : {8{$urandom}};
  end

  typedef struct { int cyc; logic [AW-1:0] aa; logic [AW-1:0] pa; } rd_t;
  typedef struct {
    int cyc; logic [7:0] mask; logic [63:0] data; logic [127:0] gamma; logic [127:0] beta;
  } beat_t;
  rd_t   rd_q[$];
  beat_t bt_q[$];
  int cyc = 0, t0 = 0, checks = 0, errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    rd_t r;
    beat_t b;
    if (act_rd_en || par_rd_en) begin
      if (rd_q.size() == 0) check("rd_unexpected", {act_rd_en, par_rd_en}, 2'b00);
      else begin
        r = rd_q.pop_front();
        check("rd_cycle", cyc, r.cyc);
        check("rd_en_pair", {act_rd_en, par_rd_en}, 2'b11);
        check("act_rd_addr", act_rd_addr, r.aa);
        check("par_rd_addr", par_rd_addr, r.pa);
      end
    end
    if ((in_fixed_data_vld | in_gamma_vld | in_beta_vld) != '0) begin
      if (bt_q.size() == 0) check("beat_unexpected", in_fixed_data_vld, 8'h00);
      else begin
        b = bt_q.pop_front();
        check("beat_cycle", cyc, b.cyc);
        check("beat_vld", {in_fixed_data_vld, in_gamma_vld, in_beta_vld}, {3{b.mask}});
        check("beat_data", in_fixed_data, b.data);
        check("beat_gamma", in_gamma, b.gamma);
        check("beat_beta", in_beta, b.beta);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  // Drives a start in the current cycle T, queues expectations, returns observing T+1
  task automatic issue(input int n, input logic [AW-1:0] base, input logic [SPW-1:0] ip,
                       input logic [SPW-1:0] op);
    int words, lanes;
    rd_t r;
    beat_t b;
    t0 = cyc;
    words = (n + BUS_NUM - 1) / BUS_NUM;
    for (int k = 0; k < words; k++) begin
      r.cyc = t0 + 1 + k;
      r.aa  = base + 8'(k);
      r.pa  = 8'(k);
      rd_q.push_back(r);
      lanes  = n - k * BUS_NUM;
      b.cyc  = t0 + 3 + k;
      b.mask = (lanes >= BUS_NUM) ? 8'hFF : 8'((1 << lanes) - 1);
      b.data = act_word(r.aa);
      b.gamma = gamma_word(r.pa);
      b.beta  = beta_word(r.pa);
      for (int i = 0; i < BUS_NUM; i++) begin
        if (!b.mask[i]) begin
          b.data[i*8 +: 8]    = '0;
          b.gamma[i*FW +: FW] = '0;
          b.beta[i*FW +: FW]  = '0;
        end
      end
      bt_q.push_back(b);
    end
    start = 1'b1;
    start_data_num = DNW'(n);
    start_base_addr = base;
    start_in_scale_pos = ip;
    start_out_scale_pos = op;
    tick();
    start = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctrl"}, {busy, done, err, act_rd_en, par_rd_en, in_data_num_vld,
                           in_scale_pos_vld, out_scale_pos_vld}, '0);
    check({tag, "_cfg"}, {act_rd_addr, par_rd_addr, in_data_num, in_scale_pos, out_scale_pos}, '0);
    check({tag, "_data"}, {in_fixed_data_vld, in_gamma_vld, in_beta_vld, in_fixed_data}, '0);
    check({tag, "_gamma"}, in_gamma, '0);
    check({tag, "_beta"}, in_beta, '0);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check_quiet("reset");
    tick();

    // N=20, base 0x10: three words, last mask 0x0F
    issue(20, 8'h10, 5'sd3, -5'sd2);
    check("cfg_num", in_data_num, 10'd20);
    check("cfg_vld", {in_data_num_vld, in_scale_pos_vld, out_scale_pos_vld}, 3'b111);
    check("cfg_pos", {in_scale_pos, out_scale_pos}, {5'b00011, 5'b11110});
    check("busy_rise", busy, 1'b1);
    tick();
    check("cfg_pulse_end", in_data_num_vld, 1'b0);
    start = 1'b1;
    start_data_num = 10'd5;
    ln_last = 1'b1;
    tick();
    start = 1'b0;
    ln_last = 1'b0;
    wait_until(t0 + 7);
    start = 1'b1;
    start_data_num = 10'd8;
    tick();
    start = 1'b0;
    wait_until(t0 + 9);
    check("wait_busy", {busy, done}, 2'b10);
    ln_last = 1'b1;
    tick();
    ln_last = 1'b0;
    check("done_n20", {busy, done}, 2'b01);
    tick();
    check("done_pulse_end", {busy, done, act_rd_en}, 3'b000);
    check("sb_empty_n20", rd_q.size() + bt_q.size(), 0);

    // N=16, base 0xFF: activation address wraps to 0x00
    issue(16, 8'hFF, 5'sd0, 5'sd0);
    wait_until(t0 + 5);
    check("wait_busy_n16", {busy, done}, 2'b10);
    ln_last = 1'b1;
    tick();
    ln_last = 1'b0;
    check("done_n16", {busy, done}, 2'b01);
    tick();
    check("sb_empty_n16", rd_q.size() + bt_q.size(), 0);

    // N=0: immediate done, nothing issued
    issue(0, 8'h30, 5'sd1, 5'sd1);
    check("n0_done", {busy, done, act_rd_en, par_rd_en, in_data_num_vld}, 5'b01000);
    tick();
    check("n0_after", {busy, done}, 2'b00);
    tick();

    // N=40 with reset during the second beat
    issue(40, 8'h20, 5'sd1, 5'sd1);
    wait_until(t0 + 4);
    rst = 1'b1;
    rd_q.delete();
    bt_q.delete();
    tick();
    rst = 1'b0;
    check_quiet("mid_rst");
    tick();
    check_quiet("post_rst");
    tick();

    // N=8 after reset; ln_last with the last beat is ignored
    issue(8, 8'h40, 5'sd2, -5'sd1);
    wait_until(t0 + 3);
    ln_last = 1'b1;
    tick();
    ln_last = 1'b0;
    check("ln_last_in_drain", {busy, done}, 2'b10);
    tick();
    ln_last = 1'b1;
    tick();
    ln_last = 1'b0;
    check("done_n8", {busy, done, err}, 3'b010);
    tick();
    check("sb_empty_n8", rd_q.size() + bt_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
